rvm_adder_arbiter: RTL and testbench
====================================

Name: rvm_adder_arbiter

Overview:
Shares the single 32-bit add/sub unit (`rvm_adder`) between several requesters in the multi-cycle core, such as PC increment, ALU and load/store address generation. Requesters arbitrate round-robin and the winner's operands are registered. The shared adder is then driven for one cycle, and the 33-bit result is held in a response register until the requester accepts it. Sits between the control FSM/datapath clients and the one adder instance.

Parameters:
NREQ, 3, number of requesters (2..8); requester 0 is index 0 of every packed bus.

Ports:
clk  input  1  core clock; all state updates on rising edge.
resetn  input  1  asynchronous, active-low reset.
req_valid  input  NREQ  per-requester request.
req_ready  output  NREQ  one-hot grant; request is accepted when req_valid[i] & req_ready[i].
req_lhs  input  32*NREQ  packed lhs operands; slice i = [32*i+31:32*i].
req_rhs  input  32*NREQ  packed rhs operands.
req_op  input  3*NREQ  packed adder op codes (`RVM_ARITH_*` encoding).
rsp_valid  output  NREQ  one-hot; response pending for requester i.
rsp_ready  input  NREQ  requester i consumes response.
rsp_result  output  33  registered adder result.
rsp_err  output  1  op was not ADD/SUB; rsp_result is 0.
adder_lhs  output  32  to shared adder lhs.
adder_rhs  output  32  to shared adder rhs.
adder_op  output  3  to shared adder op.
adder_valid  input  1  from shared adder.
adder_result  input  33  from shared adder.

Behaviour:
- State machine has three states: IDLE, BUSY and DONE. On reset: state=IDLE, last_grant=NREQ-1, rsp_valid=0, rsp_result=0, rsp_err=0, operand/op/owner registers=0.
- IDLE:
  - req_ready is the one-hot round-robin winner among req_valid.
  - Search starts at (last_grant+1) mod NREQ, ascending with wrap.
  - req_ready is all-zero if no req_valid is asserted.
  - On acceptance: latch lhs/rhs/op and owner index, set last_grant=owner, go to BUSY.
- req_ready is 0 in BUSY and DONE; there is no pipelining, one op in flight at a time.
- BUSY (exactly 1 cycle):
  - adder_lhs, adder_rhs and adder_op are driven from the registers.
  - At the clock edge, capture adder_result into rsp_result and set rsp_err = ~adder_valid.
  - Force rsp_result to 0 when op is not ADD or SUB.
  - Go to DONE.
- Outside BUSY, adder_op = `RVM_ARITH_NOP` and adder_lhs/adder_rhs = 0, so the adder inputs are isolated.
- DONE:
  - rsp_valid[owner]=1; rsp_result and rsp_err are held stable.
  - When rsp_ready[owner]=1: clear rsp_valid and go to IDLE.
  - rsp_ready on non-owner bits is ignored.
- Latency: accept at edge T, result captured at edge T+1, rsp_valid high during cycle T+1..until consumed. Minimum issue interval is 3 cycles.
- Arithmetic: unsigned 33-bit. ADD gives lhs+rhs with the carry in bit 32. SUB gives {1'b0,lhs}-rhs, so bit 32 is the borrow/sign. No wrap handling is needed beyond 33 bits.
- Requesters hold req_valid and operands stable until granted. Dropping req_valid before the grant withdraws the request without side effects.
- Simultaneous requests: only one is granted. Losers stay pending and win on subsequent rounds in rotation order.
- A requester may re-request in the same cycle it consumes its response. The request is seen in IDLE the next cycle with lowest priority for that owner.
- Reset asserted mid-operation: immediate return to reset values. In-flight operation and pending response are discarded.
- NREQ=1 degenerates to pass-through sequencing; the pointer is constant 0.

Decomposition:
- `RVM_ARITH_NOP/ADD/SUB` op codes (3'b000/001/010) are taken from `rvm_constants.v`. Add `RVM_ARB_IDLE/BUSY/DONE` (2-bit) state encodings there as well.
- One sub-module: `rvm_rr_arbiter`, a parameterised combinational round-robin one-hot picker (inputs: request vector, last_grant; output: grant vector). It is reused later for register-file and memory-port sharing.
- The adder itself stays a separate instance outside this block.

Test Plan:
- ADD, single requester: req0 valid, lhs=5, rhs=7, op=ADD -> req_ready[0]=1 at T, rsp_valid=3'b001 from T+1, rsp_result=33'h0_0000_000C, rsp_err=0.
- SUB with borrow: req1 lhs=3, rhs=5, op=SUB -> rsp_valid=3'b010, rsp_result=33'h1_FFFF_FFFE. ADD 32'hFFFF_FFFF+1 -> 33'h1_0000_0000.
- Rotation: all three req_valid held high, rsp_ready tied high -> grants in order 0,1,2,0, each 3 cycles apart. adder_op=NOP in every non-BUSY cycle.
- Backpressure: rsp_ready[0]=0 for 4 cycles after response -> rsp_valid/rsp_result stable, req_ready=0 throughout, and rsp_ready[2]=1 on the wrong bit is ignored.
- Undefined op 3'b011 from req2 -> accepted, rsp_err=1, rsp_result=0, and rotation continues normally afterwards.
- resetn low during BUSY -> next cycle state IDLE, rsp_valid=0, adder_op=NOP. After release, req0 wins first since last_grant=NREQ-1.

Source files
------------

// File: rtl/rvm_adder_arbiter_pkg.sv
// Shared constants for the adder arbiter: adder op codes, arbiter FSM states,
// and a helper that classifies ops the shared adder actually implements.
package rvm_adder_arbiter_pkg;

  localparam logic [2:0] RVM_ARITH_NOP = 3'b000;
  localparam logic [2:0] RVM_ARITH_ADD = 3'b001;
  localparam logic [2:0] RVM_ARITH_SUB = 3'b010;

  typedef enum logic [1:0] {
    RVM_ARB_IDLE = 2'd0,
    RVM_ARB_BUSY = 2'd1,
    RVM_ARB_DONE = 2'd2
  } arb_state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == RVM_ARITH_ADD) || (op == RVM_ARITH_SUB);
  endfunction

endpackage

// File: rtl/rvm_adder_arbiter_if.sv
// Requester-side request/response bus plus the link to the single shared adder.
// The arbiter uses the slave view; clients and the adder together form the master view.
interface rvm_adder_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_lhs;
  logic [32*NREQ-1:0]   req_rhs;
  logic [3*NREQ-1:0]    req_op;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [32:0]          rsp_result;
  logic                 rsp_err;
  logic [31:0]          adder_lhs;
  logic [31:0]          adder_rhs;
  logic [2:0]           adder_op;
  logic                 adder_valid;
  logic [32:0]          adder_result;

  modport slave (
    input  req_valid, req_lhs, req_rhs, req_op, rsp_ready, adder_valid, adder_result,
    output req_ready, rsp_valid, rsp_result, rsp_err, adder_lhs, adder_rhs, adder_op
  );

  modport master (
    output req_valid, req_lhs, req_rhs, req_op, rsp_ready, adder_valid, adder_result,
    input  req_ready, rsp_valid, rsp_result, rsp_err, adder_lhs, adder_rhs, adder_op
  );

endinterface

// File: rtl/rvm_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first active request
// after last_grant, searching upward with wrap. Reused for other shared resources.
module rvm_rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant
);

  logic [IW-1:0] idx;

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    grant = '0;
    idx   = '0;
    // Walk from farthest to nearest so the nearest pending requester is written last and wins.
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NREQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvm_adder_arbiter.sv
// Round-robin sharing of the single 33-bit add/sub unit: grant, drive the adder
// for one cycle, then hold the registered result until the owner consumes it.
module rvm_adder_arbiter
  import rvm_adder_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  rvm_adder_arbiter_if.slave   bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state, state_nxt;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   owner;
  logic [31:0]     lhs_q, rhs_q;
  logic [2:0]      op_q;
  logic [32:0]     result_q;
  logic            err_q;

  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] owner_onehot;
  logic            accept;
  logic [IW-1:0]   win_idx;
  logic [31:0]     win_lhs, win_rhs;
  logic [2:0]      win_op;

  rvm_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Operand mux driven by the one-hot grant; at most one slice is selected.
  always_comb begin
    win_idx = '0;
    win_lhs = '0;
    win_rhs = '0;
    win_op  = RVM_ARITH_NOP;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_idx = IW'(i);
        win_lhs = bus.req_lhs[32*i +: 32];
        win_rhs = bus.req_rhs[32*i +: 32];
        win_op  = bus.req_op[3*i +: 3];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      owner_onehot[i] = (owner == IW'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RVM_ARB_IDLE;
    else         state <= state_nxt;
  end

  // Adder inputs stay at NOP/zero outside the single BUSY cycle to keep it isolated.
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.adder_lhs = '0;
    bus.adder_rhs = '0;
    bus.adder_op  = RVM_ARITH_NOP;
    unique case (state)
      RVM_ARB_IDLE: begin
        bus.req_ready = grant;
        accept        = |(bus.req_valid & grant);
        if (accept) state_nxt = RVM_ARB_BUSY;
      end
      RVM_ARB_BUSY: begin
        bus.adder_lhs = lhs_q;
        bus.adder_rhs = rhs_q;
        bus.adder_op  = op_q;
        state_nxt     = RVM_ARB_DONE;
      end
      RVM_ARB_DONE: begin
        bus.rsp_valid = owner_onehot;
        if (|(bus.rsp_ready & owner_onehot)) state_nxt = RVM_ARB_IDLE;
      end
      default: state_nxt = RVM_ARB_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so a reset mid-operation leaves no stale operands or result visible.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= IW'(NREQ - 1);
      owner      <= '0;
      lhs_q      <= '0;
      rhs_q      <= '0;
      op_q       <= RVM_ARITH_NOP;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        lhs_q      <= win_lhs;
        rhs_q      <= win_rhs;
        op_q       <= win_op;
        owner      <= win_idx;
        last_grant <= win_idx;
      end
      if (state == RVM_ARB_BUSY) begin
        // An op the adder does not implement reports an error even if the adder claims valid.
        result_q <= is_arith(op_q) ? bus.adder_result : '0;
        err_q    <= ~bus.adder_valid | ~is_arith(op_q);
      end
    end
  end

  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_rvm_adder_arbiter.sv
// Self-checking bench: directed cases with literal expectations plus random traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_rvm_adder_arbiter;
  import rvm_adder_arbiter_pkg::*;

  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rvm_adder_arbiter_if #(.NREQ(NREQ)) bus ();

  rvm_adder_arbiter #(.NREQ(NREQ)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Requester-side stimulus, packed onto the bus.
  logic [NREQ-1:0] tb_valid, tb_rsp_ready;
  logic [31:0]     tb_lhs [NREQ];
  logic [31:0]     tb_rhs [NREQ];
  logic [2:0]      tb_op  [NREQ];

  always_comb begin
    bus.req_valid = tb_valid;
    bus.rsp_ready = tb_rsp_ready;
    for (int k = 0; k < NREQ; k++) begin
      bus.req_lhs[32*k +: 32] = tb_lhs[k];
      bus.req_rhs[32*k +: 32] = tb_rhs[k];
      bus.req_op[3*k +: 3]    = tb_op[k];
    end
  end

  // Stand-in for the shared adder; unsupported ops return junk with valid low.
  always_comb begin
    bus.adder_valid  = 1'b0;
    bus.adder_result = 33'h0_DEAD_BEEF;
    case (bus.adder_op)
      3'b001: begin
        bus.adder_valid  = 1'b1;
        bus.adder_result = {1'b0, bus.adder_lhs} + {1'b0, bus.adder_rhs};
      end
      3'b010: begin
        bus.adder_valid  = 1'b1;
        bus.adder_result = {1'b0, bus.adder_lhs} + {1'b1, ~bus.adder_rhs} + 33'd1;
      end
      default: ;
    endcase
  end

  // ---------------- reference model ----------------
  int          m_ptr   = NREQ - 1;
  bit          m_fly   = 1'b0;
  bit          m_pend  = 1'b0;
  int          m_owner = 0;
  logic [31:0] m_lhs   = '0;
  logic [31:0] m_rhs   = '0;
  logic [2:0]  m_op    = '0;
  logic [32:0] m_res   = '0;
  logic        m_err   = 1'b0;
  int          exp_win;
  logic [NREQ-1:0] exp_ready, exp_rsp;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [32:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 3'b001) return {1'b0, a} + {1'b0, b};
    if (op == 3'b010) return {1'b0, a} - {1'b0, b};
    return 33'h0;
  endfunction

  always_comb exp_win = rr_pick(bus.req_valid, m_ptr);

  always_comb begin
    exp_ready = '0;
    exp_rsp   = '0;
    if (!m_fly && !m_pend && exp_win >= 0) exp_ready = NREQ'(1) << exp_win;
    if (m_pend) exp_rsp = NREQ'(1) << m_owner;
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ptr   <= NREQ - 1;
      m_fly   <= 1'b0;
      m_pend  <= 1'b0;
      m_owner <= 0;
      m_res   <= '0;
      m_err   <= 1'b0;
    end else if (m_fly) begin
      m_fly  <= 1'b0;
      m_pend <= 1'b1;
      m_res  <= ref_result(m_op, m_lhs, m_rhs);
      m_err  <= !(m_op == 3'b001 || m_op == 3'b010);
    end else if (m_pend) begin
      if (|(bus.rsp_ready & (NREQ'(1) << m_owner))) m_pend <= 1'b0;
    end else if (exp_win >= 0) begin
      m_fly   <= 1'b1;
      m_owner <= exp_win;
      m_ptr   <= exp_win;
      m_lhs   <= 32'(bus.req_lhs >> (32 * exp_win));
      m_rhs   <= 32'(bus.req_rhs >> (32 * exp_win));
      m_op    <= 3'(bus.req_op >> (3 * exp_win));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
    if (m_pend) begin
      check("rsp_result", 64'(bus.rsp_result), 64'(m_res));
      check("rsp_err", 64'(bus.rsp_err), 64'(m_err));
    end
    check("adder_op", 64'(bus.adder_op), 64'(m_fly ? m_op : 3'b000));
    check("adder_lhs", 64'(bus.adder_lhs), 64'(m_fly ? m_lhs : 32'h0));
    check("adder_rhs", 64'(bus.adder_rhs), 64'(m_fly ? m_rhs : 32'h0));
  end

  // ---------------- directed helpers ----------------
  task automatic wait_grant(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("grant_wait", 64'(bus.req_ready), 64'(NREQ'(1) << i));
  endtask

  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [32:0] exp_res, input logic exp_err);
    @(posedge clk); #1;
    tb_lhs[i] = a; tb_rhs[i] = b; tb_op[i] = op;
    tb_valid[i] = 1'b1;
    wait_grant(i);
    @(posedge clk); #1;
    tb_valid[i] = 1'b0;
    @(negedge clk);
    check("busy_adder_op", 64'(bus.adder_op), 64'(op));
    check("busy_adder_lhs", 64'(bus.adder_lhs), 64'(a));
    @(posedge clk); #1;
    @(negedge clk);
    check("op_rsp_valid", 64'(bus.rsp_valid), 64'(NREQ'(1) << i));
    check("op_rsp_result", 64'(bus.rsp_result), 64'(exp_res));
    check("op_rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    tb_rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    tb_rsp_ready[i] = 1'b0;
    @(negedge clk);
    check("op_consumed", 64'(bus.rsp_valid), 64'(0));
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2:0] rand_op();
    int r;
    r = int'($urandom_range(9));
    if (r < 4) return 3'b001;
    if (r < 8) return 3'b010;
    return 3'($urandom_range(7));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [NREQ-1:0] hs;
    logic [NREQ-1:0] rot_exp [4];
    int got, n, last_t;
    rot_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

    tb_valid = '0;
    tb_rsp_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      tb_lhs[k] = '0; tb_rhs[k] = '0; tb_op[k] = '0;
    end

    // Reset state.
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_rsp_result", 64'(bus.rsp_result), 64'(0));
    check("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    check("rst_adder_op", 64'(bus.adder_op), 64'(RVM_ARITH_NOP));
    check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single-requester arithmetic, including carry, borrow and an unsupported op.
    do_op(0, 32'd5, 32'd7, 3'b001, 33'h0_0000_000C, 1'b0);
    do_op(0, 32'hFFFF_FFFF, 32'd1, 3'b001, 33'h1_0000_0000, 1'b0);
    do_op(1, 32'd3, 32'd5, 3'b010, 33'h1_FFFF_FFFE, 1'b0);
    do_op(2, 32'd9, 32'd4, 3'b011, 33'h0, 1'b1);

    // Rotation with all requesters active and responses always accepted.
    @(posedge clk); #1;
    for (int k = 0; k < NREQ; k++) begin
      tb_lhs[k] = 32'(10 * k); tb_rhs[k] = 32'd1; tb_op[k] = 3'b001;
    end
    tb_valid = '1;
    tb_rsp_ready = '1;
    got = 0; n = 0; last_t = 0;
    while (got < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.req_ready != '0) begin
        check("rot_grant", 64'(bus.req_ready), 64'(rot_exp[got]));
        if (got > 0) check("rot_gap", 64'(n - last_t), 64'(3));
        last_t = n;
        got++;
      end
    end
    check("rot_count", 64'(got), 64'(4));
    @(posedge clk); #1;
    tb_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    tb_rsp_ready = '0;

    // Backpressure on the owner while a wrong-bit ready and another request are present.
    @(posedge clk); #1;
    tb_lhs[0] = 32'd100; tb_rhs[0] = 32'd23; tb_op[0] = 3'b001;
    tb_valid[0] = 1'b1;
    wait_grant(0);
    @(posedge clk); #1;
    tb_valid[0] = 1'b0;
    tb_lhs[1] = 32'd1; tb_rhs[1] = 32'd1; tb_op[1] = 3'b001;
    tb_valid[1] = 1'b1;
    tb_rsp_ready = 3'b100;
    @(posedge clk); #1;
    repeat (4) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'(3'b001));
      check("bp_rsp_result", 64'(bus.rsp_result), 64'(33'h0_0000_007B));
      check("bp_req_ready", 64'(bus.req_ready), 64'(0));
    end
    tb_rsp_ready = 3'b001;
    tb_valid[1] = 1'b0;
    @(posedge clk); #1;
    tb_rsp_ready = '0;
    @(negedge clk);
    check("bp_consumed", 64'(bus.rsp_valid), 64'(0));

    // Reset while the adder is being driven.
    @(posedge clk); #1;
    tb_lhs[1] = 32'd2; tb_rhs[1] = 32'd2; tb_op[1] = 3'b001;
    tb_valid[1] = 1'b1;
    wait_grant(1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    check("rb_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rb_adder_op", 64'(bus.adder_op), 64'(RVM_ARITH_NOP));
    check("rb_rsp_result", 64'(bus.rsp_result), 64'(0));
    for (int k = 0; k < NREQ; k++) begin
      tb_lhs[k] = 32'(k + 1); tb_rhs[k] = 32'd3; tb_op[k] = 3'b010;
    end
    tb_valid = '1;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rb_first_grant", 64'(bus.req_ready), 64'(3'b001));
    @(posedge clk); #1;
    tb_valid = '0;
    tb_rsp_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    tb_rsp_ready = '0;

    // Random traffic with withdrawals, backpressure and occasional reset pulses.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      resetn = ($urandom_range(399) != 0);
      for (int k = 0; k < NREQ; k++) begin
        if (hs[k] || !tb_valid[k]) begin
          if ($urandom_range(2) == 0) begin
            tb_lhs[k] = rand_word(); tb_rhs[k] = rand_word(); tb_op[k] = rand_op();
            tb_valid[k] = 1'b1;
          end else begin
            tb_valid[k] = 1'b0;
          end
        end else if ($urandom_range(19) == 0) begin
          tb_valid[k] = 1'b0;
        end
      end
      tb_rsp_ready = NREQ'($urandom);
    end

    @(posedge clk); #1;
    resetn = 1'b1;
    tb_valid = '0;
    tb_rsp_ready = '1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
